// File: rtl/clock_alarm_pkg.sv
// Shared widths and the time-of-day record for the clock_alarm block.
package clock_alarm_pkg;

   localparam int HR_W      = 2;
   localparam int MIN_W     = 2;
   localparam int SEC_W     = 2;
   localparam int ALM_MIN_W = 3;
   localparam int DIV_W     = 16;

   typedef struct packed {
      logic [HR_W-1:0]  hours;
      logic [MIN_W-1:0] minutes;
      logic [SEC_W-1:0] seconds;
   } clk_time_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter stage: advances when en_i is high, carry_o flags the wrap.
// carry_o is combinational so a chain of stages ripples within one edge.
module mod_counter
   import clock_alarm_pkg::*;
#(
   parameter int MOD = 4,
   parameter int W   = SEC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         carry_o
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   // Reset input is active-high despite its name.
   always_ff @(posedge clk) begin
      if (rst_n) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o   = cnt_q;
   assign carry_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/clock_alarm.sv
// Time-of-day counter (prescaler + sec/min/hr chain) with a registered hh:mm alarm compare.
// Time updates on the tick edge; alarm lags the time registers by one cycle.
module clock_alarm
   import clock_alarm_pkg::*;
#(
   parameter int TICK_DIV = 1,
   parameter int SEC_MOD  = 4,
   parameter int MIN_MOD  = 4,
   parameter int HR_MOD   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [HR_W-1:0]      alarm_hours,
   input  logic [ALM_MIN_W-1:0] alarm_minutes,
   output logic [HR_W-1:0]      hours,
   output logic [MIN_W-1:0]     minutes,
   output logic [SEC_W-1:0]     seconds,
   output logic                 alarm
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             tick;
   logic             sec_carry;
   logic             min_carry;
   logic             hr_carry_unused;
   clk_time_t        now;
   logic             match;
   logic             alarm_q;
   logic             alarm_d;

   // Prescaler holds its phase while ena is low, so no tick is lost.
   always_comb begin
      div_d = div_q;
      tick  = 1'b0;
      if (ena) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            tick  = 1'b1;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) div_q <= '0;
      else       div_q <= div_d;
   end

   mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (tick),
      .cnt_o   (now.seconds),
      .carry_o (sec_carry)
   );

   mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (sec_carry),
      .cnt_o   (now.minutes),
      .carry_o (min_carry)
   );

   mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (min_carry),
      .cnt_o   (now.hours),
      .carry_o (hr_carry_unused)
   );

   // Alarm minutes are one bit wider, so settings 4..7 can never match.
   always_comb begin
      match   = (alarm_hours == now.hours) && (alarm_minutes == {1'b0, now.minutes});
      alarm_d = match;
   end

   always_ff @(posedge clk) begin
      if (rst_n) alarm_q <= 1'b0;
      else       alarm_q <= alarm_d;
   end

   assign hours   = now.hours;
   assign minutes = now.minutes;
   assign seconds = now.seconds;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm: vector table plus rollover, alarm-window and prescaler sequences.
module tb_clock_alarm;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] ah;
      logic [2:0] am;
      logic [5:0] tm;
      logic       al;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst0 = 1'b1, ena0 = 1'b0;
   logic [1:0] ah0 = 2'd0;
   logic [2:0] am0 = 3'd5;
   logic [1:0] h0, m0, s0;
   logic       al0;

   logic       rst1 = 1'b1, ena1 = 1'b0;
   logic [1:0] h1, m1, s1;
   logic       al1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   clock_alarm u_dut0 (
      .clk(clk), .rst_n(rst0), .ena(ena0),
      .alarm_hours(ah0), .alarm_minutes(am0),
      .hours(h0), .minutes(m0), .seconds(s0), .alarm(al0)
   );

   clock_alarm #(.TICK_DIV(3)) u_dut1 (
      .clk(clk), .rst_n(rst1), .ena(ena1),
      .alarm_hours(2'd3), .alarm_minutes(3'd3),
      .hours(h1), .minutes(m1), .seconds(s1), .alarm(al1)
   );

   function automatic logic [5:0] tm(input int h, input int m, input int s);
      return {2'(h), 2'(m), 2'(s)};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic step0(input logic r, input logic e, input logic [1:0] ah, input logic [2:0] am);
      rst0 = r; ena0 = e; ah0 = ah; am0 = am;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic r, input logic e);
      rst1 = r; ena1 = e;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 2'd0, 3'd5, tm(0,0,0), 1'b0, "reset_a"};
      vecs[1]  = '{1'b1, 1'b1, 2'd0, 3'd5, tm(0,0,0), 1'b0, "reset_b"};
      vecs[2]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,0,1), 1'b0, "first_tick"};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,0,2), 1'b0, "tick2"};
      vecs[4]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,0,3), 1'b0, "tick3"};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,1,0), 1'b0, "sec_carry"};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,1,1), 1'b0, "tick5"};
      vecs[7]  = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,1,2), 1'b0, "tick6"};
      vecs[8]  = '{1'b0, 1'b0, 2'd0, 3'd5, tm(0,1,2), 1'b0, "hold_a"};
      vecs[9]  = '{1'b0, 1'b0, 2'd0, 3'd5, tm(0,1,2), 1'b0, "hold_b"};
      vecs[10] = '{1'b0, 1'b1, 2'd0, 3'd5, tm(0,1,3), 1'b0, "resume"};
      vecs[11] = '{1'b1, 1'b0, 2'd0, 3'd5, tm(0,0,0), 1'b0, "rst_mid_count"};
      vecs[12] = '{1'b1, 1'b0, 2'd0, 3'd0, tm(0,0,0), 1'b0, "rst_alarm_low"};
      vecs[13] = '{1'b0, 1'b0, 2'd0, 3'd0, tm(0,0,0), 1'b1, "alarm_at_release"};
      vecs[14] = '{1'b0, 1'b0, 2'd0, 3'd1, tm(0,0,0), 1'b0, "alarm_setting_change"};

      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         step0(vecs[i].rst, vecs[i].en, vecs[i].ah, vecs[i].am);
         chk({vecs[i].name, "_time"}, int'({h0, m0, s0}), int'(vecs[i].tm));
         chk({vecs[i].name, "_alarm"}, int'(al0), int'(vecs[i].al));
      end

      // Extra hold cycles at 0:1:2 then resume.
      step0(1'b1, 1'b0, 2'd0, 3'd5);
      for (int i = 0; i < 6; i++) step0(1'b0, 1'b1, 2'd0, 3'd5);
      for (int i = 0; i < 10; i++) step0(1'b0, 1'b0, 2'd0, 3'd5);
      chk("hold10_time", int'({h0, m0, s0}), int'(tm(0,1,2)));
      step0(1'b0, 1'b1, 2'd0, 3'd5);
      chk("hold10_resume", int'({h0, m0, s0}), int'(tm(0,1,3)));

      // Full rollover with an unreachable alarm minute.
      begin
         int alarm_seen;
         alarm_seen = 0;
         step0(1'b1, 1'b0, 2'd0, 3'd5);
         for (int n = 1; n <= 64; n++) begin
            step0(1'b0, 1'b1, 2'd0, 3'd5);
            if (al0) alarm_seen++;
            chk("roll_time", int'({h0, m0, s0}), n % 64);
            if (n == 16) chk("min_carry", int'({h0, m0, s0}), int'(tm(1,0,0)));
            if (n == 63) chk("max_time", int'({h0, m0, s0}), int'(tm(3,3,3)));
            if (n == 64) chk("wrap_zero", int'({h0, m0, s0}), int'(tm(0,0,0)));
         end
         chk("unreachable_alarm", alarm_seen, 0);
      end

      // Alarm window at 2:1, with an ena=0 gap while matching.
      begin
         int ticks;
         int t_prev;
         logic e;
         logic exp_al;
         ticks = 0;
         step0(1'b1, 1'b0, 2'd2, 3'd1);
         chk("alarm_rst", int'(al0), 0);
         for (int n = 1; n <= 50; n++) begin
            e = !(n >= 38 && n <= 42);
            t_prev = ticks;
            if (e) ticks++;
            exp_al = (t_prev >= 36) && (t_prev <= 39);
            step0(1'b0, e, 2'd2, 3'd1);
            chk("win_alarm", int'(al0), int'(exp_al));
            chk("win_time", int'({h0, m0, s0}), ticks % 64);
         end
      end

      // Prescaler with TICK_DIV=3 and an ena gap mid-count.
      begin
         logic en_pat [12];
         int   exp_s  [12];
         en_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         exp_s  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
         step1(1'b1, 1'b1);
         chk("div3_reset", int'({h1, m1, s1}), 0);
         for (int i = 0; i < 12; i++) begin
            step1(1'b0, en_pat[i]);
            chk("div3_time", int'({h1, m1, s1}), exp_s[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_alarm.md
Name: clock_alarm

Overview:
- Miniature time-of-day counter with a single alarm compare. Top-level user block on the shared Tiny Tapeout-style harness.
- Counts seconds, minutes and hours from the system clock, gated by `ena`.
- Raises `alarm` while the hours/minutes time equals the programmed alarm time.
- All state is in one clock domain. There are no bus interfaces.

Parameters:
- TICK_DIV, default 1: number of enabled clk cycles per "second" tick. Legal range 1..65535. A value of 1 means one second per enabled cycle.
- SEC_MOD, default 4: seconds modulus. Must be 1..4.
- MIN_MOD, default 4: minutes modulus. Must be 1..4.
- HR_MOD, default 4: hours modulus. Must be 1..4.

Ports:
- clk, input, 1: the single system clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous reset, active-high (1 = reset), sampled on the rising clk edge. The port keeps the codebase name even though it is active-high.
- ena, input, 1: count enable. When 0 the time freezes.
- alarm_hours, input, 2: alarm hour setting.
- alarm_minutes, input, 3: alarm minute setting.
- hours, output, 2: current hour, 0..HR_MOD-1.
- minutes, output, 2: current minute, 0..MIN_MOD-1.
- seconds, output, 2: current second, 0..SEC_MOD-1.
- alarm, output, 1: registered alarm indication.

Behaviour:
- Reset (rst_n=1 at an edge): prescaler, seconds, minutes and hours all go to 0; alarm goes to 0. Reset overrides ena and dominates mid-count. Outputs take reset values on the first edge with rst_n=1.
- Prescaler: a 16-bit counter increments on each edge with ena=1.
  - At count TICK_DIV-1 it returns to 0 and issues a one-cycle tick.
  - With ena=0 it holds its value; no tick is lost or duplicated.
- Time advance on tick:
  - seconds increments.
  - At SEC_MOD-1, seconds wraps to 0 and carries into minutes.
  - At MIN_MOD-1, minutes wraps to 0 and carries into hours.
  - At HR_MOD-1, hours wraps to 0. The full rollover is 3:3:3 -> 0:0:0 with defaults.
- Carries ripple within the same edge. The time output updates exactly on the tick edge, so latency from tick to new time is 0 extra cycles.
- Outputs `hours`, `minutes` and `seconds` are direct register outputs.
- Alarm compare: `match = (alarm_hours == hours) && (alarm_minutes == {1'b0, minutes})`.
  - Seconds are ignored.
  - Any alarm_minutes value of 4..7 never matches.
- `alarm` is a register updated every edge regardless of ena: `alarm <= match`, computed from the registered time. It lags the time registers by one cycle.
- `alarm` stays high for the whole matching minute (SEC_MOD*TICK_DIV enabled cycles) and drops one cycle after the time leaves the match.
- Changing `alarm_hours`/`alarm_minutes` mid-match affects `alarm` on the next edge.
- With ena=0 and a held match, `alarm` stays high indefinitely.
- Alarm at 0:0 after reset: `alarm` rises on the first edge after reset release.
- No unknown (X) states. All registers are reset.

Decomposition:
- Shared package `clock_alarm_pkg`: width constants (HR_W=2, MIN_W=2, SEC_W=2, ALM_MIN_W=3, DIV_W=16) and a time struct typedef {hours, minutes, seconds}.
- One natural sub-module, `mod_counter`: parameterised modulus/width counter with enable-in, carry-out and synchronous reset. Instantiate it three times in a chain.
- Keep the prescaler and alarm compare inline in the top.

Test Plan:
1. Reset: hold rst_n=1 for 2 cycles with ena=1 -> hours=minutes=seconds=0, alarm=0. Release -> seconds=1 after the first edge (TICK_DIV=1).
2. Rollover: ena=1, TICK_DIV=1, run 63 edges after reset -> time 3:3:3. The next edge gives 0:0:0. Check seconds->minutes carry at edge 4 (0:1:0) and minutes->hours carry at edge 16 (1:0:0).
3. Enable gating: count to 0:1:2, drop ena for 10 cycles -> time holds at 0:1:2. Reassert ena -> the next edge gives 0:1:3.
4. Alarm match: alarm_hours=2, alarm_minutes=1 -> alarm rises exactly one edge after time reaches 2:1:0. It stays high for 4 edges and falls one edge after time becomes 2:2:0.
5. Unreachable alarm: alarm_minutes=5, alarm_hours=0, run a full 64-tick cycle -> alarm never asserts.
6. Prescaler: TICK_DIV=3 -> seconds increments every 3rd enabled edge. An ena=0 gap mid-count preserves the prescaler phase.
